byte_cmd_decoder: RTL and testbench

BYTE_CMD_DECODER -- requirements
Module: byte_cmd_decoder

---
 rtl/ucaspian_cmd_pkg.sv | 39 +++
 rtl/byte_cmd_decoder.sv | 114 +++++++++++
 tb/tb_byte_cmd_decoder.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ucaspian_cmd_pkg.sv
// Shared command definitions: opcode constants, FSM state type and opcode lookup.
package ucaspian_cmd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPayload,
        StEmit
    } state_e;

    localparam logic [7:0] OpNop       = 8'h00;
    localparam logic [7:0] OpClear     = 8'h01;
    localparam logic [7:0] OpRun       = 8'h02;
    localparam logic [7:0] OpInputFire = 8'h03;
    localparam logic [7:0] OpCfgWrite  = 8'h04;
    localparam logic [7:0] OpMetric    = 8'h05;

    typedef struct packed {
        logic       known;
        logic [2:0] len;
    } op_info_t;

    // Map an opcode byte to its payload length; unknown opcodes report known=0.
    function automatic op_info_t op_lookup(input logic [7:0] op);
        op_info_t info;
        info.known = 1'b1;
        info.len   = 3'd0;
        case (op)
            OpNop:       info.len = 3'd0;
            OpClear:     info.len = 3'd0;
            OpRun:       info.len = 3'd2;
            OpInputFire: info.len = 3'd3;
            OpCfgWrite:  info.len = 3'd4;
            OpMetric:    info.len = 3'd1;
            default:     info.known = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/byte_cmd_decoder.sv
// Byte-stream command decoder: opcode byte followed by a fixed-length payload,
// emitted as one command with a valid/ready handshake.
module byte_cmd_decoder
    import ucaspian_cmd_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned MAX_PAYLOAD = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         in_vld,
    output logic                         in_rdy,
    output logic [WIDTH-1:0]             out_op,
    output logic [WIDTH*MAX_PAYLOAD-1:0] out_payload,
    output logic [2:0]                   out_len,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [7:0]                   err_count,
    output logic                         busy
);

    localparam int unsigned PW = WIDTH * MAX_PAYLOAD;

    state_e           state_q, state_d;
    logic [2:0]       remaining_q, remaining_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic [PW-1:0]    payload_q, payload_d;
    logic [2:0]       len_q, len_d;
    logic [7:0]       err_q, err_d;

    op_info_t info;
    logic     upper_zero;
    logic     known;
    logic     in_accept;
    logic     out_accept;

    // Bytes wider than 8 bits only decode as an opcode when the extra bits are zero.
    assign upper_zero = ((in_data >> 8) == '0);
    assign info       = op_lookup(in_data[7:0]);
    assign known      = info.known && upper_zero;

    assign in_rdy     = (state_q != StEmit);
    assign out_vld    = (state_q == StEmit);
    assign busy       = (state_q != StIdle);
    assign in_accept  = in_vld && in_rdy;
    assign out_accept = out_vld && out_rdy;

    assign out_op      = op_q;
    assign out_payload = payload_q;
    assign out_len     = len_q;
    assign err_count   = err_q;

    // Next-state and datapath update for the decode FSM.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        op_d        = op_q;
        payload_d   = payload_q;
        len_d       = len_q;
        err_d       = err_q;
        case (state_q)
            StIdle: begin
                if (in_accept) begin
                    if (known) begin
                        op_d        = in_data;
                        len_d       = info.len;
                        payload_d   = '0;
                        remaining_d = info.len;
                        state_d     = (info.len != 3'd0) ? StPayload : StEmit;
                    end else if (err_q != 8'hFF) begin
                        err_d = err_q + 8'd1;
                    end
                end
            end
            StPayload: begin
                if (in_accept) begin
                    // Clearing on opcode plus left-shift keeps unused upper bytes zero.
                    payload_d   = {payload_q[PW-WIDTH-1:0], in_data};
                    remaining_d = remaining_q - 3'd1;
                    if (remaining_q == 3'd1) begin
                        state_d = StEmit;
                    end
                end
            end
            StEmit: begin
                if (out_accept) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            op_q        <= '0;
            payload_q   <= '0;
            len_q       <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            op_q        <= op_d;
            payload_q   <= payload_d;
            len_q       <= len_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_byte_cmd_decoder.sv
// Self-checking bench for byte_cmd_decoder: directed scenarios plus randomized
// streams scored against a command-level reference model.
module tb_byte_cmd_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_vld;
    logic        in_rdy;
    logic [7:0]  out_op;
    logic [31:0] out_payload;
    logic [2:0]  out_len;
    logic        out_vld;
    logic        out_rdy;
    logic [7:0]  err_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  op;
        logic [2:0]  len;
        logic [31:0] payload;
    } cmd_t;

    byte_cmd_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_vld      (in_vld),
        .in_rdy      (in_rdy),
        .out_op      (out_op),
        .out_payload (out_payload),
        .out_len     (out_len),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .err_count   (err_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance one clock; everything is driven and sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic put_byte(input logic [7:0] b);
        int n;
        in_vld  = 1'b1;
        in_data = b;
        n = 0;
        while (!in_rdy && n < 50) begin
            step();
            n++;
        end
        if (!in_rdy) begin
            checks++; errors++;
            $display("FAIL put_byte_timeout: in_rdy=%b want 1", in_rdy);
        end
        step();
        in_vld = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        in_vld  = 1'b1;
        in_data = 8'h04;
        out_rdy = 1'b1;
        step();
        reset  = 1'b0;
        in_vld = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rst_in_rdy: got %b want 1", in_rdy); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_out_vld: got %b want 0", out_vld); end
        checks++; if ({out_op, out_len, out_payload} !== 43'd0) begin
            errors++; $display("FAIL rst_outputs: op=%h len=%0d pl=%h want 0", out_op, out_len, out_payload);
        end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err: got %0d want 0", err_count); end
    endtask

    task automatic test_cfg_write();
        do_reset();
        out_rdy = 1'b1;
        put_byte(8'h04); put_byte(8'h11); put_byte(8'h22); put_byte(8'h33); put_byte(8'h44);
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL cfg_vld: got %b want 1", out_vld); end
        checks++; if (out_op !== 8'h04 || out_len !== 3'd4 || out_payload !== 32'h11223344) begin
            errors++; $display("FAIL cfg_cmd: op=%h len=%0d pl=%h want 04/4/11223344", out_op, out_len, out_payload);
        end
        step();
        checks++; if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            errors++; $display("FAIL cfg_return: out_vld=%b in_rdy=%b want 0/1", out_vld, in_rdy);
        end
    endtask

    task automatic test_hold();
        logic [42:0] snap;
        do_reset();
        out_rdy = 1'b0;
        put_byte(8'h01);
        checks++; if (out_vld !== 1'b1 || out_len !== 3'd0 || out_payload !== 32'd0 || out_op !== 8'h01) begin
            errors++; $display("FAIL hold_cmd: vld=%b op=%h len=%0d pl=%h want 1/01/0/0", out_vld, out_op, out_len, out_payload);
        end
        snap = {8'h01, 3'd0, 32'd0};
        for (int i = 0; i < 5; i++) begin
            in_vld  = 1'b1;
            in_data = 8'h02;
            step();
            checks++; if ({out_op, out_len, out_payload} !== snap || out_vld !== 1'b1 || in_rdy !== 1'b0) begin
                errors++; $display("FAIL hold_stable[%0d]: vld=%b in_rdy=%b op=%h len=%0d pl=%h", i, out_vld, in_rdy, out_op, out_len, out_payload);
            end
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        step();
        checks++; if (out_vld !== 1'b0 || in_rdy !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_release: vld=%b in_rdy=%b busy=%b want 0/1/0", out_vld, in_rdy, busy);
        end
    endtask

    task automatic test_unknown();
        do_reset();
        out_rdy = 1'b1;
        put_byte(8'h7F);
        checks++; if (err_count !== 8'd1 || out_vld !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL unk_drop: err=%0d vld=%b busy=%b want 1/0/0", err_count, out_vld, busy);
        end
        put_byte(8'h05); put_byte(8'hAA);
        checks++; if (out_vld !== 1'b1 || out_op !== 8'h05 || out_len !== 3'd1 || out_payload !== 32'h000000AA) begin
            errors++; $display("FAIL unk_metric: vld=%b op=%h len=%0d pl=%h want 1/05/1/000000AA", out_vld, out_op, out_len, out_payload);
        end
        step();
    endtask

    task automatic test_saturate();
        bit saw_vld;
        do_reset();
        out_rdy = 1'b1;
        saw_vld = 1'b0;
        for (int i = 0; i < 300; i++) begin
            put_byte(8'hFF);
            if (out_vld !== 1'b0) saw_vld = 1'b1;
        end
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_err: got %0d want 255", err_count); end
        checks++; if (saw_vld !== 1'b0) begin errors++; $display("FAIL sat_vld: got %b want 0", saw_vld); end
    endtask

    task automatic test_gap();
        do_reset();
        out_rdy = 1'b1;
        put_byte(8'h03); put_byte(8'h01); put_byte(8'h02);
        for (int i = 0; i < 10; i++) step();
        checks++; if (busy !== 1'b1 || out_vld !== 1'b0 || in_rdy !== 1'b1) begin
            errors++; $display("FAIL gap_stall: busy=%b vld=%b in_rdy=%b want 1/0/1", busy, out_vld, in_rdy);
        end
        put_byte(8'h03);
        checks++; if (out_vld !== 1'b1 || out_op !== 8'h03 || out_len !== 3'd3 || out_payload !== 32'h00010203) begin
            errors++; $display("FAIL gap_cmd: vld=%b op=%h len=%0d pl=%h want 1/03/3/00010203", out_vld, out_op, out_len, out_payload);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int n_cmds;
        do_reset();
        out_rdy = 1'b1;
        put_byte(8'h04); put_byte(8'h11);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || out_vld !== 1'b0 || out_op !== 8'h00) begin
            errors++; $display("FAIL midp_reset: busy=%b vld=%b op=%h want 0/0/00", busy, out_vld, out_op);
        end
        n_cmds = 0;
        put_byte(8'h02); put_byte(8'h04); put_byte(8'h05);
        if (out_vld === 1'b1) n_cmds++;
        checks++; if (out_op !== 8'h02 || out_payload !== 32'h00000405 || out_len !== 3'd2) begin
            errors++; $display("FAIL midp_cmd: op=%h len=%0d pl=%h want 02/2/00000405", out_op, out_len, out_payload);
        end
        step();
        if (out_vld === 1'b1) n_cmds++;
        step();
        if (out_vld === 1'b1) n_cmds++;
        checks++; if (n_cmds != 1) begin errors++; $display("FAIL midp_count: got %0d cmds want 1", n_cmds); end
        // Pending command in EMIT must be discarded by reset.
        out_rdy = 1'b0;
        put_byte(8'h02); put_byte(8'hAA); put_byte(8'hBB);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        out_rdy = 1'b1;
        step();
        checks++; if (out_vld !== 1'b0 || busy !== 1'b0 || out_payload !== 32'd0) begin
            errors++; $display("FAIL mide_discard: vld=%b busy=%b pl=%h want 0/0/0", out_vld, busy, out_payload);
        end
    endtask

    // Random stream of whole commands (some unknown opcodes), scored cycle by cycle.
    task automatic test_random(input int n_items, input int vld_pct, input int rdy_pct);
        int         len_tab [6] = '{0, 0, 2, 3, 4, 1};
        logic [7:0] bytes_q[$];
        bit         done_q[$];
        cmd_t       exp_q[$];
        cmd_t       c;
        logic [7:0] b;
        int         unk, idx, cycles, len;
        bit         pending, acc_in, acc_out;

        unk = 0;
        for (int i = 0; i < n_items; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                bytes_q.push_back(8'($urandom_range(6, 255)));
                done_q.push_back(1'b0);
                unk++;
            end else begin
                c.op      = 8'($urandom_range(0, 5));
                len       = len_tab[c.op];
                c.len     = 3'(len);
                c.payload = 32'd0;
                bytes_q.push_back(c.op);
                done_q.push_back(len == 0);
                for (int k = 0; k < len; k++) begin
                    // Half the payload bytes look like opcodes.
                    b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
                    c.payload = (c.payload << 8) | 32'(b);
                    bytes_q.push_back(b);
                    done_q.push_back(k == len - 1);
                end
                exp_q.push_back(c);
            end
        end

        do_reset();
        idx     = 0;
        cycles  = 0;
        pending = 1'b0;
        while ((idx < bytes_q.size() || pending) && cycles < 5000) begin
            checks++; if (out_vld !== pending) begin
                errors++; $display("FAIL rnd_vld: cycle %0d got %b want %b", cycles, out_vld, pending);
            end
            checks++; if (in_rdy !== !pending) begin
                errors++; $display("FAIL rnd_in_rdy: cycle %0d got %b want %b", cycles, in_rdy, !pending);
            end
            if (pending) begin
                checks++; if (out_op !== exp_q[0].op || out_len !== exp_q[0].len || out_payload !== exp_q[0].payload) begin
                    errors++; $display("FAIL rnd_cmd: op=%h len=%0d pl=%h want %h/%0d/%h", out_op, out_len, out_payload, exp_q[0].op, exp_q[0].len, exp_q[0].payload);
                end
            end
            in_vld  = (idx < bytes_q.size()) && ($urandom_range(0, 99) < vld_pct);
            in_data = in_vld ? bytes_q[idx] : 8'($urandom_range(0, 255));
            out_rdy = ($urandom_range(0, 99) < rdy_pct);
            acc_in  = in_vld && !pending;
            acc_out = pending && out_rdy;
            step();
            if (acc_out) begin
                void'(exp_q.pop_front());
                pending = 1'b0;
            end
            if (acc_in) begin
                if (done_q[idx]) pending = 1'b1;
                idx++;
            end
            cycles++;
        end
        in_vld = 1'b0;
        if (cycles >= 5000) begin
            checks++; errors++;
            $display("FAIL rnd_timeout: consumed %0d of %0d bytes", idx, bytes_q.size());
        end
        checks++; if (err_count !== 8'((unk > 255) ? 255 : unk)) begin
            errors++; $display("FAIL rnd_err: got %0d want %0d", err_count, unk);
        end
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL rnd_left: %0d commands never emitted want 0", exp_q.size());
        end
    endtask

    initial begin
        reset   = 1'b0;
        in_vld  = 1'b0;
        in_data = 8'h00;
        out_rdy = 1'b0;
        step();
        test_reset();
        test_cfg_write();
        test_hold();
        test_unknown();
        test_saturate();
        test_gap();
        test_reset_mid();
        test_random(40, 70, 60);
        test_random(40, 100, 100);
        test_random(40, 30, 20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
